// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: forward encodings,
// FSM states and the shadow scoreboard entry layouts.
package pipe_hazard_ctrl_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b01;
   localparam logic [1:0] FWD_MEMWB = 2'b10;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } hz_state_e;

   // EX keeps sources for forwarding and MemRead for load-use; later stages only need the destination
   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic                  wr;
      logic                  ld;
   } ex_entry_t;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic                  wr;
   } dst_entry_t;

   function automatic logic [1:0] fwd_select(
      input logic [REG_ADDR_W-1:0] rs,
      input dst_entry_t            mem_e,
      input dst_entry_t            wb_e
   );
      logic [1:0] sel;
      sel = FWD_RF;
      if (mem_e.wr && (mem_e.rd != '0) && (mem_e.rd == rs)) begin
         sel = FWD_EXMEM;
      end else if (wb_e.wr && (wb_e.rd != '0) && (wb_e.rd == rs)) begin
         sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shadow copy of rd/rs/RegWrite/MemRead for EX, MEM and WB, plus the
// forwarding compare for the instruction sitting in EX.
module hazard_scoreboard
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  hold_i,
   input  logic                  ex_bubble_i,
   input  logic [REG_ADDR_W-1:0] id_rs1_i,
   input  logic [REG_ADDR_W-1:0] id_rs2_i,
   input  logic [REG_ADDR_W-1:0] id_rd_i,
   input  logic                  id_regwrite_i,
   input  logic                  id_memread_i,
   output logic [REG_ADDR_W-1:0] ex_rd_o,
   output logic                  ex_wr_o,
   output logic                  ex_ld_o,
   output logic [1:0]            fwd_a_sel_o,
   output logic [1:0]            fwd_b_sel_o
);

   ex_entry_t  ex_q, ex_d;
   dst_entry_t mem_q, mem_d;
   dst_entry_t wb_q, wb_d;

   // A frozen MEM stage still retires nothing, so WB sees a bubble while EX and MEM hold
   always_comb begin
      ex_d  = ex_q;
      mem_d = mem_q;
      wb_d  = wb_q;
      if (hold_i) begin
         wb_d = '0;
      end else begin
         wb_d     = mem_q;
         mem_d.rd = ex_q.rd;
         mem_d.wr = ex_q.wr;
         if (ex_bubble_i) begin
            ex_d = '0;
         end else begin
            ex_d.rd  = id_rd_i;
            ex_d.rs1 = id_rs1_i;
            ex_d.rs2 = id_rs2_i;
            ex_d.wr  = id_regwrite_i;
            ex_d.ld  = id_memread_i;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_q  <= '0;
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         ex_q  <= ex_d;
         mem_q <= mem_d;
         wb_q  <= wb_d;
      end
   end

   assign ex_rd_o     = ex_q.rd;
   assign ex_wr_o     = ex_q.wr;
   assign ex_ld_o     = ex_q.ld;
   assign fwd_a_sel_o = fwd_select(ex_q.rs1, mem_q, wb_q);
   assign fwd_b_sel_o = fwd_select(ex_q.rs2, mem_q, wb_q);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline: load-use
// bubbles, EX redirects and data-memory wait freezes with a watchdog.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 64,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid_i,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic             id_use_rs1_i,
   input  logic             id_use_rs2_i,
   input  logic [4:0]       id_rd_i,
   input  logic             id_regwrite_i,
   input  logic             id_memread_i,
   input  logic             ex_redirect_i,
   input  logic             mem_access_i,
   input  logic             dmem_ready_i,
   output logic             pc_stall_o,
   output logic             if_id_stall_o,
   output logic             if_id_flush_o,
   output logic             id_ex_stall_o,
   output logic             id_ex_flush_o,
   output logic             ex_mem_stall_o,
   output logic             mem_wb_bubble_o,
   output logic [1:0]       fwd_a_sel_o,
   output logic [1:0]       fwd_b_sel_o,
   output logic             mem_timeout_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   hz_state_e         state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   logic                  freeze;
   logic                  load_use;
   logic [REG_ADDR_W-1:0] ex_rd;
   logic                  ex_wr;
   logic                  ex_ld;
   logic [1:0]            sb_fwd_a;
   logic [1:0]            sb_fwd_b;

   assign freeze = mem_access_i & ~dmem_ready_i;

   assign load_use = ex_ld & ex_wr & (ex_rd != '0) & id_valid_i &
                     ((id_use_rs1_i & (id_rs1_i == ex_rd)) |
                      (id_use_rs2_i & (id_rs2_i == ex_rd)));

   hazard_scoreboard u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .hold_i        (freeze),
      .ex_bubble_i   (id_ex_flush_o | ~id_valid_i),
      .id_rs1_i      (id_rs1_i),
      .id_rs2_i      (id_rs2_i),
      .id_rd_i       (id_rd_i),
      .id_regwrite_i (id_regwrite_i),
      .id_memread_i  (id_memread_i),
      .ex_rd_o       (ex_rd),
      .ex_wr_o       (ex_wr),
      .ex_ld_o       (ex_ld),
      .fwd_a_sel_o   (sb_fwd_a),
      .fwd_b_sel_o   (sb_fwd_b)
   );

   // Freeze outranks redirect (EX cannot move), and redirect kills the instruction causing load-use
   always_comb begin
      pc_stall_o      = 1'b0;
      if_id_stall_o   = 1'b0;
      if_id_flush_o   = 1'b0;
      id_ex_stall_o   = 1'b0;
      id_ex_flush_o   = 1'b0;
      ex_mem_stall_o  = 1'b0;
      mem_wb_bubble_o = 1'b0;
      if (rst_n) begin
         if (freeze) begin
            pc_stall_o      = 1'b1;
            if_id_stall_o   = 1'b1;
            id_ex_stall_o   = 1'b1;
            ex_mem_stall_o  = 1'b1;
            mem_wb_bubble_o = 1'b1;
         end else if (ex_redirect_i) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end else if (load_use) begin
            pc_stall_o    = 1'b1;
            if_id_stall_o = 1'b1;
            id_ex_flush_o = 1'b1;
         end
      end
   end

   assign fwd_a_sel_o = rst_n ? sb_fwd_a : FWD_RF;
   assign fwd_b_sel_o = rst_n ? sb_fwd_b : FWD_RF;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN:      if (freeze)  state_d = ST_MEM_WAIT;
         ST_MEM_WAIT: if (!freeze) state_d = ST_RUN;
         default:     state_d = ST_RUN;
      endcase

      wait_cnt_d = '0;
      if (freeze) begin
         wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
      timeout_d = timeout_q | (wait_cnt_d == WAIT_LIMIT);

      stall_cnt_d = stall_cnt_q;
      if (pc_stall_o && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign mem_timeout_o = timeout_q;
   assign stall_cnt_o   = stall_cnt_q;

endmodule
